// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read-first output.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Depth];

  // Contents are deliberately not reset so they survive a core reset.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we == WE_WORD) begin
        mem[addr] <= wdata;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (we[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time, inserts wait states, then
// commits the read/write to the RAM and pulses ready for one cycle.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_address_i,
  input  logic [31:0] data_mem_write_i,
  input  logic [3:0]  data_mem_we_i,
  output logic [31:0] data_mem_read_o,
  output logic        data_mem_ready_o,
  output logic        data_mem_busy_o,
  output logic        data_mem_err_o
);

  localparam int unsigned AddrW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WaitLoad = WAIT_W'(WAIT_CYCLES);
  localparam logic [29:0] DepthIdx = 30'(DEPTH_WORDS);

  dmem_state_e       state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [29:0]       idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        we_q;
  logic              ready_q;
  logic              err_q;

  logic        accept;
  logic        commit;
  logic        in_range;
  logic        ram_en;
  logic [29:0] cur_idx;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_we;
  logic [31:0] ram_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^data_mem_address_i[1:0];

  always_comb begin
    accept = (state_q == StIdle) && data_mem_req_i;
    // With zero wait states the commit edge is the acceptance edge, so use the live inputs.
    if (state_q == StIdle) begin
      cur_idx   = data_mem_address_i[31:2];
      cur_wdata = data_mem_write_i;
      cur_we    = data_mem_we_i;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_we    = we_q;
    end
    in_range = cur_idx < DepthIdx;
    commit   = rst_n && ((accept && (WAIT_CYCLES == 0)) ||
                         ((state_q == StWait) && (cnt_q == WAIT_W'(1))));
    ram_en   = commit && in_range;
  end

  dmem_array #(
    .Depth (DEPTH_WORDS),
    .AddrW (AddrW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    ((cur_we == WE_READ) ? WE_READ : cur_we),
    .addr  (cur_idx[AddrW-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= WE_READ;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= commit;
      err_q   <= commit && !in_range;
      unique case (state_q)
        StIdle: begin
          if (data_mem_req_i) begin
            idx_q   <= data_mem_address_i[31:2];
            wdata_q <= data_mem_write_i;
            we_q    <= data_mem_we_i;
            cnt_q   <= WaitLoad;
            state_q <= (WAIT_CYCLES > 0) ? StWait : StResp;
          end
        end
        StWait: begin
          if (cnt_q == WAIT_W'(1)) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_mem_ready_o = ready_q;
  assign data_mem_err_o   = err_q;
  assign data_mem_read_o  = (ready_q && !err_q) ? ram_rdata : '0;
  assign data_mem_busy_o  = rst_n && (accept || (state_q == StWait));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked against a
// word-level memory model with directed cases and randomized traffic.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        req   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  we    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        busy  [3];
  logic        err   [3];

  int checks   = 0;
  int failures = 0;

  bit [31:0] mdl [longint];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n[0]), .data_mem_req_i(req[0]), .data_mem_address_i(addr[0]),
    .data_mem_write_i(wdata[0]), .data_mem_we_i(we[0]), .data_mem_read_o(rdata[0]),
    .data_mem_ready_o(ready[0]), .data_mem_busy_o(busy[0]), .data_mem_err_o(err[0])
  );
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n[1]), .data_mem_req_i(req[1]), .data_mem_address_i(addr[1]),
    .data_mem_write_i(wdata[1]), .data_mem_we_i(we[1]), .data_mem_read_o(rdata[1]),
    .data_mem_ready_o(ready[1]), .data_mem_busy_o(busy[1]), .data_mem_err_o(err[1])
  );
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n[2]), .data_mem_req_i(req[2]), .data_mem_address_i(addr[2]),
    .data_mem_write_i(wdata[2]), .data_mem_we_i(we[2]), .data_mem_read_o(rdata[2]),
    .data_mem_ready_o(ready[2]), .data_mem_busy_o(busy[2]), .data_mem_err_o(err[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // One transaction on instance k; optionally disturbs the inputs during the wait.
  task automatic txn(input int k, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wen, input bit perturb, input logic [31:0] alt,
                     output logic [31:0] got);
    logic [29:0] idx;
    logic [31:0] old;
    logic [31:0] nw;
    bit          inr;
    bit          known;
    bit          done;
    longint      key;
    int          n;
    int          nbusy;
    int          w;
    w     = wait_of(k);
    idx   = a[31:2];
    inr   = idx < 30'd1024;
    key   = (longint'(k) << 32) | longint'(idx);
    known = inr && mdl.exists(key);
    old   = known ? mdl[key] : 32'h0;
    @(negedge clk);
    req[k] = 1'b1; addr[k] = a; wdata[k] = wd; we[k] = wen;
    #1;
    check_eq("busy_accept", busy[k], 1);
    n = 0; nbusy = 1; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (ready[k]) done = 1'b1;
      else if (busy[k]) nbusy++;
      if (n == 1) begin
        req[k] = 1'b0;
        if (perturb) begin
          addr[k] = alt; wdata[k] = $urandom; we[k] = 4'hF;
        end
      end
    end
    got = rdata[k];
    check_eq("latency", n, w + 1);
    check_eq("busy_cycles", nbusy, w + 1);
    check_eq("busy_resp", busy[k], 0);
    check_eq("err", err[k], {31'b0, !inr});
    if (!inr) check_eq("rd_oor_zero", rdata[k], 32'h0);
    else if (known) check_eq("rd_data", rdata[k], old);
    @(negedge clk);
    check_eq("ready_pulse", ready[k], 0);
    if (done && inr && wen != 4'h0) begin
      if (wen == 4'hF) begin
        mdl[key] = wd;
      end else if (known) begin
        nw = old;
        for (int b = 0; b < 4; b++) if (wen[b]) nw[8*b +: 8] = wd[8*b +: 8];
        mdl[key] = nw;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] alt;
    logic [3:0]  wen;

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b1; addr[k] = '0; wdata[k] = '0; we[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", ready[k], 0);
      check_eq("rst_busy", busy[k], 0);
      check_eq("rst_read", rdata[k], 32'h0);
      check_eq("rst_err", err[k], 0);
      req[k] = 1'b0; rst_n[k] = 1'b1;
    end

    // Word write/read and byte lanes, WAIT_CYCLES=1.
    txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, got);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, got);
    check_eq("rd_deadbeef", got, 32'hDEADBEEF);
    txn(0, 32'h10, 32'h000000AA, 4'b0001, 0, 0, got);
    check_eq("wr_returns_old", got, 32'hDEADBEEF);
    txn(0, 32'h10, 32'h00CC0000, 4'b0100, 0, 0, got);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, got);
    check_eq("rd_lanes", got, 32'hDECCBEAA);

    // Out-of-range accesses leave the array alone.
    txn(0, 32'h0, 32'h11111111, 4'hF, 0, 0, got);
    txn(0, 32'h00001000, 32'hFFFFFFFF, 4'hF, 0, 0, got);
    txn(0, 32'h00001000, 32'h0, 4'h0, 0, 0, got);
    check_eq("rd_oor", got, 32'h0);
    txn(0, 32'h80000010, 32'h00000055, 4'hF, 0, 0, got);
    txn(0, 32'h0, 32'h0, 4'h0, 0, 0, got);
    check_eq("word0_kept", got, 32'h11111111);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0, got);
    check_eq("no_alias", got, 32'hDECCBEAA);

    // Inputs disturbed during the wait must not redirect the transaction.
    txn(0, 32'h34, 32'h01020304, 4'hF, 0, 0, got);
    txn(0, 32'h30, 32'h0BADC0DE, 4'hF, 1, 32'h34, got);
    txn(0, 32'h34, 32'h0, 4'h0, 0, 0, got);
    check_eq("alt_untouched", got, 32'h01020304);
    txn(0, 32'h30, 32'h0, 4'h0, 0, 0, got);
    check_eq("orig_written", got, 32'h0BADC0DE);

    // Zero wait states, then back-to-back with req held high.
    txn(1, 32'h40, 32'h600DF00D, 4'hF, 0, 0, got);
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h40; we[1] = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq("b2b_ready", ready[1], (i % 2 == 1) ? 1 : 0);
      check_eq("b2b_busy", busy[1], (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 1) check_eq("b2b_data", rdata[1], 32'h600DF00D);
      if (i == 8) req[1] = 1'b0;
    end

    // Reset during the wait discards the write and emits no ready.
    txn(2, 32'h20, 32'hA5A50F0F, 4'hF, 0, 0, got);
    @(negedge clk);
    req[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678; we[2] = 4'hF;
    @(negedge clk);
    req[2] = 1'b0; addr[2] = 32'h24; rst_n[2] = 1'b0;
    @(negedge clk);
    check_eq("mrst_ready", ready[2], 0);
    check_eq("mrst_busy", busy[2], 0);
    check_eq("mrst_read", rdata[2], 32'h0);
    check_eq("mrst_err", err[2], 0);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("mrst_no_ready", ready[2], 0);
    end
    txn(2, 32'h20, 32'h0, 4'h0, 0, 0, got);
    check_eq("mrst_ram_kept", got, 32'hA5A50F0F);

    // Randomized traffic over a small pool plus out-of-range addresses.
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 8; p++) txn(k, 32'h100 + 32'(p * 4), $urandom, 4'hF, 0, 0, got);
      for (int t = 0; t < 40; t++) begin
        if ($urandom_range(0, 7) == 0) a = 32'h00001000 | ($urandom & 32'hFFFF_FFFC);
        else a = 32'h100 + 32'($urandom_range(0, 7) * 4);
        a   = a | 32'($urandom_range(0, 3));
        alt = 32'h100 + 32'($urandom_range(0, 7) * 4);
        wen = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        txn(k, a, $urandom, wen, ($urandom_range(0, 1) == 1), alt, got);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
